// File: rtl/ta_cap_seq_50.sv
// Capture sequencer, 50 MHz domain: trigger-started sample capture into RAM, then handshaked readout.
// Optional capture timeout is enabled by defining TA_CAP_TIMEOUT_EN.
module ta_cap_seq_50 #(
   parameter int DW      = 16,
   parameter int AW      = 10,
   parameter int CAP_LEN = 1024,
   parameter int TIMEOUT = 50000000
) (
   input  logic          Ga_clk50,
   input  logic          Ga_rst_n,
   input  logic          Ga_cap_trig,
   input  logic          Ga_cap_cmpt,
   input  logic          Ga_smp_vld,
   input  logic [DW-1:0] Ga_smp_data,
   output logic          Ga_wr_en,
   output logic [AW-1:0] Ga_wr_addr,
   output logic [DW-1:0] Ga_wr_data,
   input  logic          Ga_rd_start,
   input  logic          Ga_rd_ready,
   output logic          Ga_rd_en,
   output logic [AW-1:0] Ga_rd_addr,
   output logic          Ga_busy,
   output logic          Ga_cap_done,
   output logic [AW:0]   Ga_cap_cnt,
   output logic          Ga_trig_miss,
   output logic          Ga_timeout
);

   typedef enum logic [1:0] {IDLE, CAPT, HOLD, READ} state_t;

   localparam logic [AW:0] LAST = (AW+1)'(CAP_LEN-1);

   state_t      state, state_nxt;
   logic [AW:0] cnt;
   logic [AW:0] rd_idx;
   logic        full_hit;
   logic        tmo_hit;
   logic        cap_end;
   logic        trig_acc;

   assign trig_acc = (state == IDLE) && Ga_cap_trig;
   // A sample landing on the last slot ends the capture in the same cycle it is written.
   assign full_hit = Ga_smp_vld && (cnt == LAST);
   assign cap_end  = Ga_cap_cmpt || full_hit || tmo_hit;
   assign Ga_busy  = (state != IDLE);

`ifdef TA_CAP_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   assign tmo_hit = (state == CAPT) && (tmo_cnt == 32'(TIMEOUT-1));

   always_ff @(posedge Ga_clk50 or negedge Ga_rst_n) begin
      if (!Ga_rst_n) begin
         tmo_cnt    <= '0;
         Ga_timeout <= 1'b0;
      end else if (trig_acc) begin
         tmo_cnt    <= '0;
         Ga_timeout <= 1'b0;
      end else if (state == CAPT) begin
         tmo_cnt <= tmo_cnt + 32'd1;
         // Flag only a pure timeout; complete/full on the same edge take precedence.
         if (tmo_hit && !Ga_cap_cmpt && !full_hit)
            Ga_timeout <= 1'b1;
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo = ^32'(TIMEOUT);
   assign tmo_hit    = 1'b0;
   assign Ga_timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (Ga_cap_trig) state_nxt = CAPT;
         CAPT: if (cap_end) state_nxt = HOLD;
         HOLD: if (Ga_rd_start) state_nxt = (Ga_cap_cnt == '0) ? IDLE : READ;
         READ: if (Ga_rd_ready && (rd_idx == Ga_cap_cnt - (AW+1)'(1))) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Ga_clk50 or negedge Ga_rst_n) begin
      if (!Ga_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         rd_idx       <= '0;
         Ga_wr_en     <= 1'b0;
         Ga_wr_addr   <= '0;
         Ga_wr_data   <= '0;
         Ga_rd_en     <= 1'b0;
         Ga_rd_addr   <= '0;
         Ga_cap_done  <= 1'b0;
         Ga_cap_cnt   <= '0;
         Ga_trig_miss <= 1'b0;
      end else begin
         state        <= state_nxt;
         Ga_wr_en     <= 1'b0;
         Ga_rd_en     <= 1'b0;
         Ga_cap_done  <= 1'b0;
         Ga_trig_miss <= Ga_cap_trig && (state != IDLE);
         case (state)
            IDLE: begin
               if (Ga_cap_trig) begin
                  cnt        <= '0;
                  Ga_cap_cnt <= '0;
               end
            end
            CAPT: begin
               if (Ga_smp_vld) begin
                  Ga_wr_en   <= 1'b1;
                  Ga_wr_addr <= cnt[AW-1:0];
                  Ga_wr_data <= Ga_smp_data;
                  cnt        <= cnt + (AW+1)'(1);
               end
               if (cap_end) begin
                  Ga_cap_done <= 1'b1;
                  Ga_cap_cnt  <= cnt + (AW+1)'(Ga_smp_vld);
               end
            end
            HOLD: begin
               if (Ga_rd_start) rd_idx <= '0;
            end
            READ: begin
               if (Ga_rd_ready) begin
                  Ga_rd_en   <= 1'b1;
                  Ga_rd_addr <= rd_idx[AW-1:0];
                  rd_idx     <= rd_idx + (AW+1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ta_cap_seq_50.sv
// Directed bench for ta_cap_seq_50 with a write/read address scoreboard.
module tb_ta_cap_seq_50;
   localparam int DW = 16;
   localparam int AW = 10;

   logic          Ga_clk50 = 1'b0;
   logic          Ga_rst_n;
   logic          Ga_cap_trig, Ga_cap_cmpt, Ga_smp_vld;
   logic [DW-1:0] Ga_smp_data;
   logic          Ga_wr_en;
   logic [AW-1:0] Ga_wr_addr;
   logic [DW-1:0] Ga_wr_data;
   logic          Ga_rd_start, Ga_rd_ready;
   logic          Ga_rd_en;
   logic [AW-1:0] Ga_rd_addr;
   logic          Ga_busy, Ga_cap_done, Ga_trig_miss, Ga_timeout;
   logic [AW:0]   Ga_cap_cnt;

   ta_cap_seq_50 #(.DW(DW), .AW(AW), .CAP_LEN(8), .TIMEOUT(100)) dut (
      .Ga_clk50(Ga_clk50), .Ga_rst_n(Ga_rst_n),
      .Ga_cap_trig(Ga_cap_trig), .Ga_cap_cmpt(Ga_cap_cmpt),
      .Ga_smp_vld(Ga_smp_vld), .Ga_smp_data(Ga_smp_data),
      .Ga_wr_en(Ga_wr_en), .Ga_wr_addr(Ga_wr_addr), .Ga_wr_data(Ga_wr_data),
      .Ga_rd_start(Ga_rd_start), .Ga_rd_ready(Ga_rd_ready),
      .Ga_rd_en(Ga_rd_en), .Ga_rd_addr(Ga_rd_addr),
      .Ga_busy(Ga_busy), .Ga_cap_done(Ga_cap_done), .Ga_cap_cnt(Ga_cap_cnt),
      .Ga_trig_miss(Ga_trig_miss), .Ga_timeout(Ga_timeout)
   );

   always #10 Ga_clk50 = ~Ga_clk50;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           wr_q[$];
   logic [AW-1:0] rd_q[$];
   wr_t           mon_e;
   logic [AW-1:0] mon_ra;
   int            n_chk = 0, n_err = 0;
   int            n_done = 0, n_miss = 0, n_rd = 0;
   bit            mon_off = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Ga_clk50);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"},   Ga_wr_en, 0);
      chk({tag, "_wr_addr"}, Ga_wr_addr, 0);
      chk({tag, "_wr_data"}, Ga_wr_data, 0);
      chk({tag, "_rd_en"},   Ga_rd_en, 0);
      chk({tag, "_rd_addr"}, Ga_rd_addr, 0);
      chk({tag, "_busy"},    Ga_busy, 0);
      chk({tag, "_done"},    Ga_cap_done, 0);
      chk({tag, "_cnt"},     Ga_cap_cnt, 0);
      chk({tag, "_miss"},    Ga_trig_miss, 0);
      chk({tag, "_tmo"},     Ga_timeout, 0);
   endtask

   // Scoreboard side: every strobe must match the next expected entry.
   always @(negedge Ga_clk50) begin
      if (Ga_rst_n && !mon_off) begin
         if (Ga_wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected", Ga_wr_en, 0);
            else begin
               mon_e = wr_q.pop_front();
               chk("wr_addr", Ga_wr_addr, mon_e.a);
               chk("wr_data", Ga_wr_data, mon_e.d);
            end
         end
         if (Ga_rd_en) begin
            n_rd++;
            if (rd_q.size() == 0) chk("rd_unexpected", Ga_rd_en, 0);
            else begin
               mon_ra = rd_q.pop_front();
               chk("rd_addr", Ga_rd_addr, mon_ra);
            end
         end
         if (Ga_cap_done)  n_done++;
         if (Ga_trig_miss) n_miss++;
      end
   end

   initial begin
      logic [5:0] pat;
      int         k;
      Ga_rst_n = 1'b0; Ga_cap_trig = 0; Ga_cap_cmpt = 0; Ga_smp_vld = 0;
      Ga_smp_data = '0; Ga_rd_start = 0; Ga_rd_ready = 0;
      repeat (3) @(posedge Ga_clk50);
      #1;
      chk_zero("rst");
      Ga_rst_n = 1'b1;
      step();

      // 5 samples, last one together with complete; a trigger mid-capture is a miss
      Ga_cap_trig = 1; step(); Ga_cap_trig = 0;
      for (int i = 0; i < 5; i++) begin
         Ga_smp_vld = 1; Ga_smp_data = DW'(16'h11 + i);
         wr_q.push_back('{a: AW'(i), d: DW'(16'h11 + i)});
         if (i == 1) Ga_cap_trig = 1;
         if (i == 4) Ga_cap_cmpt = 1;
         step();
         Ga_cap_trig = 0;
      end
      Ga_cap_cmpt = 0;
      chk("p1_done_pulse", Ga_cap_done, 1);
      chk("p1_done_with_wr", Ga_wr_en, 1);
      Ga_smp_data = 16'hEE; step();
      Ga_smp_vld = 0; step();
      chk("p1_n_done", n_done, 1);
      chk("p1_n_miss", n_miss, 1);
      chk("p1_cap_cnt", Ga_cap_cnt, 5);
      chk("p1_busy", Ga_busy, 1);
      chk("p1_wr_drained", wr_q.size(), 0);

      // trigger in HOLD, then readout with ready 1,0,1,1,1,1
      Ga_cap_trig = 1; step(); Ga_cap_trig = 0; step();
      chk("p2_n_miss", n_miss, 2);
      chk("p2_cap_cnt", Ga_cap_cnt, 5);
      Ga_rd_start = 1; step(); Ga_rd_start = 0;
      pat = 6'b111101; k = 0;
      for (int j = 0; j < 6; j++) begin
         Ga_rd_ready = pat[j];
         if (pat[j]) begin rd_q.push_back(AW'(k)); k++; end
         if (j == 3) Ga_rd_start = 1;
         step();
         Ga_rd_start = 0;
         chk("p2_rd_en", Ga_rd_en, pat[j]);
      end
      step(); step();
      Ga_rd_ready = 0; step();
      chk("p2_busy", Ga_busy, 0);
      chk("p2_n_rd", n_rd, 5);
      chk("p2_rd_drained", rd_q.size(), 0);

      // buffer full: 12 continuous samples, only 8 land
      Ga_cap_trig = 1; step(); Ga_cap_trig = 0;
      for (int i = 0; i < 12; i++) begin
         Ga_smp_vld = 1; Ga_smp_data = DW'(16'h100 + i);
         if (i < 8) wr_q.push_back('{a: AW'(i), d: DW'(16'h100 + i)});
         step();
         if (i == 7) chk("p3_done_8th", Ga_cap_done, 1);
      end
      Ga_smp_vld = 0; step();
      chk("p3_cap_cnt", Ga_cap_cnt, 8);
      chk("p3_n_done", n_done, 2);
      chk("p3_wr_drained", wr_q.size(), 0);
      Ga_rd_start = 1; step(); Ga_rd_start = 0;
      Ga_rd_ready = 1;
      for (int i = 0; i < 8; i++) rd_q.push_back(AW'(i));
      repeat (10) step();
      Ga_rd_ready = 0; step();
      chk("p3_busy", Ga_busy, 0);
      chk("p3_n_rd", n_rd, 13);
      chk("p3_rd_drained", rd_q.size(), 0);

      // empty capture; trigger in HOLD; read start goes straight to IDLE
      Ga_cap_trig = 1; step(); Ga_cap_trig = 0;
      Ga_cap_cmpt = 1; step(); Ga_cap_cmpt = 0; step();
      chk("p4_cap_cnt", Ga_cap_cnt, 0);
      chk("p4_n_done", n_done, 3);
      chk("p4_busy_hold", Ga_busy, 1);
      Ga_cap_trig = 1; step(); Ga_cap_trig = 0; step();
      chk("p4_n_miss", n_miss, 3);
      chk("p4_cap_cnt_kept", Ga_cap_cnt, 0);
      Ga_rd_start = 1; Ga_rd_ready = 1; step(); Ga_rd_start = 0;
      repeat (3) step();
      Ga_rd_ready = 0;
      chk("p4_busy", Ga_busy, 0);
      chk("p4_n_rd", n_rd, 13);

      // 3 samples and no complete
      Ga_cap_trig = 1; step(); Ga_cap_trig = 0;
      k = 0;
      for (int i = 0; i < 3; i++) begin
         Ga_smp_vld = 1; Ga_smp_data = DW'(16'hA0 + i);
         wr_q.push_back('{a: AW'(i), d: DW'(16'hA0 + i)});
         step(); k++;
      end
      Ga_smp_vld = 0;
`ifdef TA_CAP_TIMEOUT_EN
      while (!Ga_cap_done && k < 200) begin step(); k++; end
      chk("p5_tmo_cycle", k, 100);
      chk("p5_tmo_flag", Ga_timeout, 1);
      step();
      chk("p5_cap_cnt", Ga_cap_cnt, 3);
      chk("p5_n_done", n_done, 4);
`else
      repeat (150) step();
      chk("p5_no_done", n_done, 3);
      chk("p5_busy", Ga_busy, 1);
      chk("p5_tmo_flag", Ga_timeout, 0);
      Ga_cap_cmpt = 1; step(); Ga_cap_cmpt = 0; step();
      chk("p5_cap_cnt", Ga_cap_cnt, 3);
      chk("p5_n_done", n_done, 4);
`endif
      chk("p5_wr_drained", wr_q.size(), 0);
      Ga_rd_start = 1; step(); Ga_rd_start = 0;
      Ga_rd_ready = 1;
      for (int i = 0; i < 3; i++) rd_q.push_back(AW'(i));
      repeat (5) step();
      Ga_rd_ready = 0; step();
      chk("p5_busy_idle", Ga_busy, 0);
      chk("p5_rd_drained", rd_q.size(), 0);

      // new trigger clears timeout; async reset mid-capture
      Ga_cap_trig = 1; step(); Ga_cap_trig = 0;
      chk("p6_tmo_clr", Ga_timeout, 0);
      mon_off = 1'b1;
      Ga_smp_vld = 1; Ga_smp_data = 16'h55;
      step(); step();
      chk("p6_wr_active", Ga_wr_en, 1);
      #2 Ga_rst_n = 1'b0;
      #1 chk_zero("arst");
      Ga_smp_vld = 0;
      step();
      Ga_rst_n = 1'b1;
      wr_q.delete(); rd_q.delete();
      mon_off = 1'b0;
      step();
      chk("p6_busy", Ga_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ta_cap_seq_50.md
Name: ta_cap_seq_50

Overview:
Capture sequencer in the 50 MHz domain. It sits directly downstream of the 125-to-50 MHz trigger/complete crossing stage and consumes its single-cycle Ga_cap_trig and Ga_cap_cmpt pulses. On trigger it writes the incoming sample stream into a sample RAM, stops on complete, buffer-full or timeout, then replays the captured addresses to a reader under a ready handshake.

Parameters:
DW, 16, sample data width
AW, 10, RAM address width
CAP_LEN, 1024, maximum samples per capture; legal range 1..2^AW
TIMEOUT, 50000000, CAPT cycles before forced stop; used only with the optional feature

Ports:
Ga_clk50  in  1  50 MHz clock; the only clock
Ga_rst_n  in  1  reset, asynchronous, active-low
Ga_cap_trig  in  1  single-cycle trigger pulse from the crossing stage
Ga_cap_cmpt  in  1  single-cycle complete pulse from the crossing stage
Ga_smp_vld  in  1  sample valid
Ga_smp_data  in  DW  sample data
Ga_wr_en  out  1  RAM write strobe
Ga_wr_addr  out  AW  RAM write address
Ga_wr_data  out  DW  RAM write data
Ga_rd_start  in  1  pulse; starts readout
Ga_rd_ready  in  1  reader can accept one word this cycle
Ga_rd_en  out  1  RAM read strobe
Ga_rd_addr  out  AW  RAM read address
Ga_busy  out  1  high in CAPT, HOLD or READ
Ga_cap_done  out  1  one-cycle pulse when capture ends
Ga_cap_cnt  out  AW+1  number of samples captured
Ga_trig_miss  out  1  one-cycle pulse: trigger dropped while not IDLE
Ga_timeout  out  1  sticky: last capture ended by timeout

Behaviour:
- Reset (async assert, synchronous release by flops): state=IDLE; all outputs 0; all counters 0.
- States: IDLE, CAPT, HOLD, READ (encoded in 2 bits).
- IDLE:
  - Ga_cap_trig -> CAPT; sample counter cnt=0; Ga_timeout cleared.
  - Ga_cap_cmpt, Ga_rd_start, Ga_smp_vld are ignored.
- CAPT:
  - Write path is registered, 1-cycle latency. Ga_smp_vld high at edge k gives Ga_wr_en=1 in cycle k+1, with Ga_wr_addr=cnt and Ga_wr_data=sample; cnt increments.
  - End conditions, checked at the same edge:
    - Ga_cap_cmpt.
    - The write of index CAP_LEN-1.
    - Timeout (optional feature).
  - Sample plus complete in the same cycle: the sample is written, then capture ends.
  - Samples after the end condition are never written.
  - On end: next state HOLD. Ga_cap_done=1 for exactly one cycle, coincident with the last Ga_wr_en if any. Ga_cap_cnt=final cnt, held until the next trigger is accepted.
  - Complete with no samples gives Ga_cap_cnt=0.
- Ga_cap_trig in CAPT, HOLD or READ: ignored, Ga_trig_miss pulses 1 cycle later, and the capture in progress or held is not disturbed.
- HOLD:
  - Ga_rd_start -> READ with rd index=0.
  - If Ga_cap_cnt==0, Ga_rd_start -> IDLE directly and no reads are issued.
- READ:
  - Ga_rd_ready high at edge k gives Ga_rd_en=1 in cycle k+1 with Ga_rd_addr=index; index increments.
  - Ga_rd_ready low means no strobe and the index holds.
  - After the strobe for index Ga_cap_cnt-1, next state IDLE and no further strobes.
  - Ga_rd_start in READ is ignored.
- Ga_busy is combinational from state and is 0 only in IDLE.
- Counter widths: cnt is AW+1 bits, so CAP_LEN=2^AW reports 2^AW without wrap. Addresses use the low AW bits.
- Reset mid-operation: immediate return to IDLE with strobes 0; RAM contents undefined to the sequencer.

Optional Feature:
- Macro TA_CAP_TIMEOUT_EN.
- Defined:
  - A 32-bit cycle counter clears on trigger accept and counts every CAPT cycle.
  - On reaching TIMEOUT-1 with no other end condition, capture ends exactly as on complete and Ga_timeout sets.
  - Ga_timeout clears on the next accepted trigger or on reset.
  - If timeout coincides with complete or full, Ga_timeout stays 0.
- Undefined: no counter; Ga_timeout is tied 0; capture waits indefinitely for complete or full.

Test Plan:
- Trigger, then 5 valid samples 0x11..0x15, then complete -> Ga_wr_en x5 at addr 0..4 with matching data; Ga_cap_done once; Ga_cap_cnt=5; state HOLD.
- CAP_LEN=8, trigger, continuous valid for 12 cycles -> exactly 8 writes at addr 0..7; Ga_cap_done with the 8th; Ga_cap_cnt=8; samples 9-12 dropped.
- In HOLD with cnt=5, Ga_rd_start, Ga_rd_ready toggling 1,0,1,1,1,1 -> Ga_rd_en addr 0..4 only on cycles after ready; back to IDLE after addr 4.
- Trigger then immediate complete, then Ga_rd_start -> Ga_cap_cnt=0; no Ga_rd_en; IDLE. Second trigger during HOLD -> Ga_trig_miss pulse; Ga_cap_cnt unchanged.
- TA_CAP_TIMEOUT_EN, TIMEOUT=100: trigger, 3 samples, no complete -> capture ends 100 cycles after trigger; Ga_timeout=1; Ga_cap_cnt=3. Ga_rst_n low during CAPT -> all outputs 0 asynchronously.
